// File: rtl/pong_pkg.sv
// Shared types and geometry helpers for the Pong game-state engine.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    PL_NONE = 2'd0,
    PL_ONE  = 2'd1,
    PL_TWO  = 2'd2
  } player_t;

  typedef logic signed [10:0] coord_t;

  localparam int unsigned STICK_CENTRE = 128;

  // Top-left coordinate that centres an object of `size` along `extent`.
  function automatic coord_t centre_pos(input int unsigned extent, input int unsigned size);
    return coord_t'((extent - size) / 2);
  endfunction

  function automatic coord_t mid_of(input coord_t pos, input int unsigned size);
    return pos + coord_t'(size / 2);
  endfunction

  // Negative coordinates never reach the display; they saturate to 0.
  function automatic logic [9:0] to_pix(input coord_t c);
    return c[10] ? '0 : c[9:0];
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: stick dead band or ball tracking, fixed-speed step, clamp to the playfield.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_SZ      = 8,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned DEADZONE     = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  logic       ai_i,
  input  logic [7:0] stick_i,
  input  coord_t     ball_y_i,
  output coord_t     y_o
);

  localparam coord_t     Y_MAX = coord_t'(SCREEN_H - PADDLE_H);
  localparam coord_t     SPEED = coord_t'(PADDLE_SPEED);
  localparam logic [7:0] UP_TH = 8'(STICK_CENTRE + DEADZONE);
  localparam logic [7:0] DN_TH = 8'(STICK_CENTRE - DEADZONE);

  coord_t y_q, y_d;
  coord_t paddle_mid, ball_mid, moved;
  logic   go_up, go_down;

  always_comb begin
    paddle_mid = mid_of(y_q, PADDLE_H);
    ball_mid   = mid_of(ball_y_i, BALL_SZ);
    if (ai_i) begin
      go_up   = paddle_mid > ball_mid + SPEED;
      go_down = ball_mid > paddle_mid + SPEED;
    end else begin
      // Larger stick value means up, i.e. towards smaller y.
      go_up   = stick_i > UP_TH;
      go_down = stick_i < DN_TH;
    end

    moved = y_q;
    if (go_up) begin
      moved = y_q - SPEED;
    end else if (go_down) begin
      moved = y_q + SPEED;
    end

    y_d = moved;
    if (moved < coord_t'(0)) begin
      y_d = '0;
    end else if (moved > Y_MAX) begin
      y_d = Y_MAX;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q <= centre_pos(SCREEN_H, PADDLE_H);
    end else if (step_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_state_engine.sv
// Per-frame Pong engine: serve/play/point/over sequencing, ball physics and scoring.
module pong_state_engine
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned PADDLE_W     = 6,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_SZ      = 8,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned DEADZONE     = 24,
  parameter int unsigned SPEED_INIT   = 2,
  parameter int unsigned SPEED_MAX    = 6,
  parameter int unsigned BALL_VY      = 2,
  parameter int unsigned MAX_SCORE    = 7,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [7:0] stick_y1,
  input  logic [7:0] stick_y2,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       ai_mode,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state,
  output logic [1:0] winner
);

  localparam coord_t BALL_X0 = centre_pos(SCREEN_W, BALL_SZ);
  localparam coord_t BALL_Y0 = centre_pos(SCREEN_H, BALL_SZ);
  localparam coord_t Y_BOT   = coord_t'(SCREEN_H - BALL_SZ);
  localparam coord_t X_HIT1  = coord_t'(PADDLE_W);
  localparam coord_t X_HIT2  = coord_t'(SCREEN_W - PADDLE_W - BALL_SZ);
  localparam coord_t X_OUT2  = coord_t'(SCREEN_W - BALL_SZ);
  localparam coord_t P_H     = coord_t'(PADDLE_H);
  localparam coord_t B_SZ    = coord_t'(BALL_SZ);
  localparam coord_t VY      = coord_t'(BALL_VY);

  localparam logic [2:0]     SPD_INIT   = 3'(SPEED_INIT);
  localparam logic [2:0]     SPD_MAX    = 3'(SPEED_MAX);
  localparam logic [3:0]     SCORE_WIN  = 4'(MAX_SCORE);
  localparam int unsigned    PCW        = $clog2(PAUSE_FRAMES + 2);
  localparam logic [PCW-1:0] PAUSE_LOAD = PCW'(PAUSE_FRAMES);
  localparam logic [PCW-1:0] PAUSE_ONE  = PCW'(1);

  game_state_t    state_q;
  player_t        server_q, winner_q;
  coord_t         bx_q, by_q;
  logic           dir_x_q;  // 1 = towards paddle 2
  logic           dir_y_q;  // 1 = down
  logic [2:0]     speed_q;
  logic [3:0]     s1_q, s2_q;
  logic [PCW-1:0] pause_q;

  coord_t p1_y, p2_y;
  logic   paddle_step;

  assign paddle_step = frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY);

  pong_paddle #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .BALL_SZ     (BALL_SZ),
    .PADDLE_SPEED(PADDLE_SPEED),
    .DEADZONE    (DEADZONE)
  ) u_paddle1 (
    .clk_i   (clkin),
    .rst_i   (rst),
    .step_i  (paddle_step),
    .ai_i    (1'b0),
    .stick_i (stick_y1),
    .ball_y_i(by_q),
    .y_o     (p1_y)
  );

  pong_paddle #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .BALL_SZ     (BALL_SZ),
    .PADDLE_SPEED(PADDLE_SPEED),
    .DEADZONE    (DEADZONE)
  ) u_paddle2 (
    .clk_i   (clkin),
    .rst_i   (rst),
    .step_i  (paddle_step),
    .ai_i    (ai_mode),
    .stick_i (stick_y2),
    .ball_y_i(by_q),
    .y_o     (p2_y)
  );

  coord_t     spd, nx, ny;
  logic       ndir_y, hit1, hit2, miss_left, miss_right;
  logic [2:0] speed_up;

  // Candidate ball move; paddle overlap uses the wall-adjusted y and pre-update paddles.
  always_comb begin
    spd    = coord_t'(speed_q);
    nx     = dir_x_q ? bx_q + spd : bx_q - spd;
    ny     = dir_y_q ? by_q + VY : by_q - VY;
    ndir_y = dir_y_q;
    if (ny <= coord_t'(0)) begin
      ny     = '0;
      ndir_y = 1'b1;
    end else if (ny >= Y_BOT) begin
      ny     = Y_BOT;
      ndir_y = 1'b0;
    end
    hit1       = !dir_x_q && (nx <= X_HIT1) && (ny + B_SZ > p1_y) && (ny < p1_y + P_H);
    hit2       = dir_x_q && (nx >= X_HIT2) && (ny + B_SZ > p2_y) && (ny < p2_y + P_H);
    miss_left  = !dir_x_q && (nx <= coord_t'(0)) && !hit1;
    miss_right = dir_x_q && (nx >= X_OUT2) && !hit2;
    speed_up   = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 3'd1;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SERVE;
      server_q <= PL_ONE;
      winner_q <= PL_NONE;
      bx_q     <= BALL_X0;
      by_q     <= BALL_Y0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      speed_q  <= SPD_INIT;
      s1_q     <= '0;
      s2_q     <= '0;
      pause_q  <= '0;
    end else if (frame_tick) begin
      unique case (state_q)
        ST_SERVE: begin
          if ((server_q == PL_ONE && btn1) || (server_q == PL_TWO && btn2)) begin
            state_q <= ST_PLAY;
            speed_q <= SPD_INIT;
            dir_x_q <= (server_q == PL_ONE);
            dir_y_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_left || miss_right) begin
            if (miss_left) begin
              s2_q     <= s2_q + 4'd1;
              server_q <= PL_ONE;
            end else begin
              s1_q     <= s1_q + 4'd1;
              server_q <= PL_TWO;
            end
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
            pause_q <= PAUSE_LOAD;
            state_q <= ST_POINT;
          end else begin
            bx_q    <= nx;
            by_q    <= ny;
            dir_y_q <= ndir_y;
            if (hit1) begin
              bx_q    <= X_HIT1;
              dir_x_q <= 1'b1;
              speed_q <= speed_up;
            end else if (hit2) begin
              bx_q    <= X_HIT2;
              dir_x_q <= 1'b0;
              speed_q <= speed_up;
            end
          end
        end
        ST_POINT: begin
          if (pause_q > PAUSE_ONE) begin
            pause_q <= pause_q - PAUSE_ONE;
          end else begin
            pause_q <= '0;
            if (s1_q == SCORE_WIN) begin
              winner_q <= PL_ONE;
              state_q  <= ST_OVER;
            end else if (s2_q == SCORE_WIN) begin
              winner_q <= PL_TWO;
              state_q  <= ST_OVER;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        ST_OVER: begin
          if (btn1 && btn2) begin
            s1_q     <= '0;
            s2_q     <= '0;
            winner_q <= PL_NONE;
            server_q <= PL_ONE;
            state_q  <= ST_SERVE;
          end
        end
      endcase
    end
  end

  assign ball_x     = to_pix(bx_q);
  assign ball_y     = to_pix(by_q);
  assign paddle1_y  = to_pix(p1_y);
  assign paddle2_y  = to_pix(p2_y);
  assign score1     = s1_q;
  assign score2     = s2_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_state_engine.sv
// Directed bench for pong_state_engine: paddles, serve, wall/paddle bounces, scoring, match end, AI, reset.
module tb_pong_state_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [7:0] sy1, sy2;
  logic       btn1, btn2, ai_mode;
  logic [9:0] ball_x, ball_y, p1, p2;
  logic [3:0] s1, s2;
  logic [1:0] gs, win;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pong_state_engine #(
    .SCREEN_W    (640),
    .SCREEN_H    (480),
    .PADDLE_W    (6),
    .PADDLE_H    (64),
    .BALL_SZ     (8),
    .PADDLE_SPEED(4),
    .DEADZONE    (24),
    .SPEED_INIT  (2),
    .SPEED_MAX   (6),
    .BALL_VY     (2),
    .MAX_SCORE   (7),
    .PAUSE_FRAMES(60)
  ) dut (
    .clkin     (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .stick_y1  (sy1),
    .stick_y2  (sy2),
    .btn1      (btn1),
    .btn2      (btn2),
    .ai_mode   (ai_mode),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .paddle1_y (p1),
    .paddle2_y (p2),
    .score1    (s1),
    .score2    (s2),
    .game_state(gs),
    .winner    (win)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int bx, input int by, input int ep1, input int ep2,
                         input int es1, input int es2, input int egs, input int ew);
    chk({tag, ".ball_x"}, 32'(ball_x), bx);
    chk({tag, ".ball_y"}, 32'(ball_y), by);
    chk({tag, ".p1"}, 32'(p1), ep1);
    chk({tag, ".p2"}, 32'(p2), ep2);
    chk({tag, ".score1"}, 32'(s1), es1);
    chk({tag, ".score2"}, 32'(s2), es2);
    chk({tag, ".state"}, 32'(gs), egs);
    chk({tag, ".winner"}, 32'(win), ew);
  endtask

  // n back-to-back frame ticks, then return at a negedge with frame_tick low.
  task automatic ticks(input int n);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic chk_ball(input string tag, input int bx, input int by, input int egs);
    chk({tag, ".ball_x"}, 32'(ball_x), bx);
    chk({tag, ".ball_y"}, 32'(ball_y), by);
    chk({tag, ".state"}, 32'(gs), egs);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; sy1 = 8'd128; sy2 = 8'd128;
    btn1 = 1'b0; btn2 = 1'b0; ai_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 316, 236, 208, 208, 0, 0, 0, 0);
    rst = 1'b0;

    // Without frame_tick nothing moves, even with a button and stick active.
    btn1 = 1'b1; sy1 = 8'd255;
    repeat (5) @(negedge clk);
    chk_all("no_tick", 316, 236, 208, 208, 0, 0, 0, 0);
    btn1 = 1'b0;

    // Paddle travel and clamps.
    sy2 = 8'd0;
    ticks(1);
    chk("p1_step1", 32'(p1), 204);
    chk("p2_step1", 32'(p2), 212);
    ticks(51);
    chk("p1_at_top", 32'(p1), 0);
    chk("p2_at_bot", 32'(p2), 416);
    ticks(8);
    chk("p1_clamp_top", 32'(p1), 0);
    chk("p2_clamp_bot", 32'(p2), 416);
    sy1 = 8'd128;
    ticks(1);
    chk("p1_centre_hold", 32'(p1), 0);
    sy2 = 8'd153; ticks(1); chk("p2_dz_153", 32'(p2), 412);
    sy2 = 8'd104; ticks(1); chk("p2_dz_104", 32'(p2), 412);
    sy2 = 8'd103; ticks(1); chk("p2_dz_103", 32'(p2), 416);
    sy2 = 8'd152; ticks(1); chk("p2_dz_152", 32'(p2), 416);
    sy2 = 8'd128;

    btn2 = 1'b1; ticks(1); btn2 = 1'b0;
    chk_ball("btn2_wrong_server", 316, 236, 0);

    // Rally 1: player 1 serves right, paddle 2 at 416 misses.
    btn1 = 1'b1; ticks(1); btn1 = 1'b0;
    chk_ball("serve1", 316, 236, 1);
    ticks(1);   chk_ball("r1_k1", 318, 238, 1);
    ticks(116); chk_ball("r1_k117", 550, 470, 1);
    ticks(1);   chk_ball("r1_bottom", 552, 472, 1);
    ticks(1);   chk_ball("r1_k119", 554, 470, 1);
    ticks(38);  chk_all("r1_k157", 630, 394, 0, 416, 0, 0, 1, 0);
    ticks(1);   chk_all("r1_point", 316, 236, 0, 416, 1, 0, 2, 0);

    // Pause freezes paddles; ends after exactly 60 ticks.
    sy2 = 8'd255;
    ticks(59); chk_all("pause59", 316, 236, 0, 416, 1, 0, 2, 0);
    ticks(1);  chk("pause_end", 32'(gs), 0);
    sy2 = 8'd128;

    // Server is now player 2.
    btn1 = 1'b1; ticks(1); btn1 = 1'b0;
    chk("btn1_wrong_server", 32'(gs), 0);
    sy1 = 8'd0; ticks(92); sy1 = 8'd128;
    chk("p1_to_368", 32'(p1), 368);
    sy2 = 8'd255; ticks(12); sy2 = 8'd128;
    chk("p2_to_368", 32'(p2), 368);

    // Rally 2: ball left, hits paddle 1, speeds up, crosses, misses paddle 2.
    btn2 = 1'b1; ticks(1); btn2 = 1'b0;
    chk_ball("serve2", 316, 236, 1);
    ticks(154); chk_ball("r2_k154", 8, 400, 1);
    ticks(1);   chk_ball("r2_hit_p1", 6, 398, 1);
    ticks(1);   chk_ball("r2_speed3", 9, 396, 1);
    ticks(198); chk_ball("r2_top", 603, 0, 1);
    ticks(1);   chk_ball("r2_after_top", 606, 2, 1);
    ticks(8);   chk_ball("r2_j208", 630, 18, 1);
    ticks(1);   chk_all("r2_point", 316, 236, 368, 368, 2, 0, 2, 0);
    ticks(60);  chk("r2_pause_end", 32'(gs), 0);

    // Rally 3: player 2 serves, paddle 1 moved to the top misses.
    sy1 = 8'd255; ticks(92); sy1 = 8'd128;
    chk("p1_back_0", 32'(p1), 0);
    btn2 = 1'b1; ticks(1); btn2 = 1'b0;
    ticks(157); chk_ball("r3_k157", 2, 394, 1);
    ticks(1);   chk_all("r3_point", 316, 236, 0, 368, 2, 1, 2, 0);
    ticks(60);  chk("r3_pause_end", 32'(gs), 0);

    // Player 1 serves six times; paddle 2 returns, paddle 1 misses each time.
    sy1 = 8'd0; ticks(92); sy1 = 8'd128;
    chk("p1_to_368_b", 32'(p1), 368);
    for (int i = 0; i < 6; i++) begin
      btn1 = 1'b1; ticks(1); btn1 = 1'b0;
      chk_ball($sformatf("loop%0d_serve", i), 316, 236, 1);
      ticks(155); chk_ball($sformatf("loop%0d_hit_p2", i), 626, 398, 1);
      ticks(1);   chk_ball($sformatf("loop%0d_back", i), 623, 396, 1);
      ticks(207); chk_ball($sformatf("loop%0d_j208", i), 2, 18, 1);
      ticks(1);
      chk_all($sformatf("loop%0d_point", i), 316, 236, 368, 368, 2, 2 + i, 2, 0);
      ticks(59);  chk($sformatf("loop%0d_pause59", i), 32'(gs), 2);
      ticks(1);
      chk($sformatf("loop%0d_after_pause", i), 32'(gs), (i < 5) ? 0 : 3);
      chk($sformatf("loop%0d_winner", i), 32'(win), (i < 5) ? 0 : 2);
    end

    // Game over: everything frozen until both buttons at a tick.
    sy1 = 8'd255; sy2 = 8'd0;
    ticks(5);  chk_all("over_frozen", 316, 236, 368, 368, 2, 7, 3, 2);
    btn1 = 1'b1; ticks(1); btn1 = 1'b0;
    chk("over_btn1_only", 32'(gs), 3);
    btn2 = 1'b1; ticks(1);
    chk("over_btn2_only", 32'(gs), 3);
    btn1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("over_no_tick", 32'(gs), 3);
    sy1 = 8'd128; sy2 = 8'd128;
    ticks(1);  btn1 = 1'b0; btn2 = 1'b0;
    chk_all("restart", 316, 236, 368, 368, 0, 0, 0, 0);
    btn2 = 1'b1; ticks(1); btn2 = 1'b0;
    chk("restart_server1", 32'(gs), 0);

    // AI paddle 2 tracks the centred ball and ignores its stick.
    ai_mode = 1'b1; sy2 = 8'd0;
    ticks(1);  chk("ai_step1", 32'(p2), 364);
    ticks(38); chk("ai_settle", 32'(p2), 212);
    ticks(6);  chk("ai_hold", 32'(p2), 212);
    chk("ai_p1_unmoved", 32'(p1), 368);

    // Asynchronous reset in the middle of play.
    btn1 = 1'b1; ticks(1); btn1 = 1'b0;
    ticks(3); chk_ball("pre_reset", 322, 242, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 316, 236, 208, 208, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; ai_mode = 1'b0; sy2 = 8'd128;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
